// File: rtl/pic_pkg.sv
// Shared types and helpers for the interrupt acknowledge sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pic_pkg;

    localparam int LEVEL_W    = 3;
    localparam int VEC_W      = 8;
    localparam int NUM_LEVELS = 1 << LEVEL_W;
    localparam int RANK_W     = LEVEL_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACK1,
        ACK2
    } state_t;

    // A spurious acknowledge reports level 7, as the original 8259 does.
    localparam logic [NUM_LEVELS-1:0] SPURIOUS_LEVEL = 8'h80;

    function automatic logic [NUM_LEVELS-1:0] level_decode(input logic [LEVEL_W-1:0] lvl);
        return NUM_LEVELS'(1) << lvl;
    endfunction

    function automatic logic [LEVEL_W-1:0] onehot_index(input logic [NUM_LEVELS-1:0] v);
        logic [LEVEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (v[i]) idx = idx | LEVEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pending_resolver.sv
// Rotated-priority arbiter: picks the highest-priority pending level and decides eligibility.
// Latency: purely combinational.
// Backpressure: none.
module pending_resolver
    import pic_pkg::*;
(
    input  logic [NUM_LEVELS-1:0] pending,
    input  logic [LEVEL_W-1:0]    priority_rotate,
    input  logic [NUM_LEVELS-1:0] highest_level_in_service,
    input  logic                  special_mask_mode,
    output logic [NUM_LEVELS-1:0] winner,
    output logic                  eligible
);

    logic [LEVEL_W-1:0] lvl;
    logic [RANK_W-1:0]  win_rank;
    logic [RANK_W-1:0]  isr_rank;
    logic               found;
    logic               isr_found;

    // Rank 0 is the level just above priority_rotate; an empty ISR keeps rank NUM_LEVELS,
    // below every real level.
    always_comb begin
        winner    = '0;
        found     = 1'b0;
        isr_found = 1'b0;
        win_rank  = RANK_W'(NUM_LEVELS);
        isr_rank  = RANK_W'(NUM_LEVELS);
        lvl       = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            lvl = priority_rotate + LEVEL_W'(i + 1);
            if (!found && pending[lvl]) begin
                winner[lvl] = 1'b1;
                found       = 1'b1;
                win_rank    = RANK_W'(i);
            end
            if (!isr_found && highest_level_in_service[lvl]) begin
                isr_found = 1'b1;
                isr_rank  = RANK_W'(i);
            end
        end
        eligible = found && (special_mask_mode || (win_rank < isr_rank));
    end

endmodule

// File: rtl/inta_sequencer.sv
// 8259-style INTA sequencer: raises int_out, runs the two-pulse acknowledge, drives the vector, issues EOIs.
// Latency: request to int_out 1 cycle; INTA edge to pulses/vector on the same clock as the state change.
// Backpressure: none; the CPU paces the sequence through inta_n.
module inta_sequencer
    import pic_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_LEVELS-1:0] interrupt_request_register,
    input  logic [NUM_LEVELS-1:0] interrupt_mask,
    input  logic [NUM_LEVELS-1:0] highest_level_in_service,
    input  logic [LEVEL_W-1:0]    priority_rotate,
    input  logic                  special_mask_mode,
    input  logic                  inta_n,
    input  logic [4:0]            vector_base,
    input  logic                  auto_eoi_config,
    input  logic                  eoi_command,
    input  logic                  eoi_specific,
    input  logic [LEVEL_W-1:0]    eoi_level,
    output logic                  int_out,
    output logic                  latch_in_service,
    output logic [NUM_LEVELS-1:0] interrupt,
    output logic [NUM_LEVELS-1:0] clear_interrupt_request,
    output logic [NUM_LEVELS-1:0] end_of_interrupt,
    output logic [VEC_W-1:0]      data_out,
    output logic                  data_out_enable
);

    state_t                state, state_nxt;
    logic [NUM_LEVELS-1:0] pending, winner;
    logic                  eligible;
    logic                  inta_prev, inta_edge;
    logic                  spurious, spurious_nxt;
    logic                  int_out_nxt, latch_nxt;
    logic [NUM_LEVELS-1:0] interrupt_nxt, clear_nxt, eoi_nxt;
    logic [NUM_LEVELS-1:0] auto_eoi_vec, cmd_eoi_vec;
    logic [VEC_W-1:0]      data_out_nxt;

    assign pending   = interrupt_request_register & ~interrupt_mask;
    assign inta_edge = inta_prev && !inta_n;

    pending_resolver u_resolver (
        .pending                  (pending),
        .priority_rotate          (priority_rotate),
        .highest_level_in_service (highest_level_in_service),
        .special_mask_mode        (special_mask_mode),
        .winner                   (winner),
        .eligible                 (eligible)
    );

    always_comb begin
        state_nxt     = state;
        spurious_nxt  = spurious;
        int_out_nxt   = 1'b0;
        latch_nxt     = 1'b0;
        interrupt_nxt = interrupt;
        clear_nxt     = '0;
        data_out_nxt  = data_out;
        auto_eoi_vec  = '0;
        cmd_eoi_vec   = '0;
        if (eoi_command) begin
            cmd_eoi_vec = eoi_specific ? level_decode(eoi_level) : highest_level_in_service;
        end
        case (state)
            IDLE: begin
                if (inta_edge) begin
                    state_nxt     = ACK1;
                    spurious_nxt  = !eligible;
                    interrupt_nxt = eligible ? winner : SPURIOUS_LEVEL;
                    latch_nxt     = eligible;
                    clear_nxt     = eligible ? winner : '0;
                end else begin
                    int_out_nxt = eligible;
                end
            end
            ACK1: begin
                // Vector is built from the level frozen at the first edge, not the live requests.
                if (inta_edge) begin
                    state_nxt    = ACK2;
                    data_out_nxt = {vector_base, onehot_index(interrupt)};
                end
            end
            ACK2: begin
                if (inta_n) begin
                    state_nxt = IDLE;
                    if (auto_eoi_config && !spurious) auto_eoi_vec = interrupt;
                end
            end
            default: state_nxt = IDLE;
        endcase
        eoi_nxt = auto_eoi_vec | cmd_eoi_vec;
    end

    // inta_prev resets low so an inta_n held low across reset is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= IDLE;
            inta_prev               <= 1'b0;
            spurious                <= 1'b0;
            int_out                 <= 1'b0;
            latch_in_service        <= 1'b0;
            interrupt               <= '0;
            clear_interrupt_request <= '0;
            end_of_interrupt        <= '0;
            data_out                <= '0;
        end else begin
            state                   <= state_nxt;
            inta_prev               <= inta_n;
            spurious                <= spurious_nxt;
            int_out                 <= int_out_nxt;
            latch_in_service        <= latch_nxt;
            interrupt               <= interrupt_nxt;
            clear_interrupt_request <= clear_nxt;
            end_of_interrupt        <= eoi_nxt;
            data_out                <= data_out_nxt;
        end
    end

    assign data_out_enable = (state == ACK2) && !inta_n;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: per-cycle compare against a rank-based reference model
// plus literal expectations for the acknowledge, rotation, blocking, EOI and reset cases.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irr, mask, isr;
    logic [2:0] rot, eoi_level;
    logic       smm, inta_n, auto_eoi, eoi_command, eoi_specific;
    logic [4:0] vb;
    logic       int_out, latch, den;
    logic [7:0] interrupt, clear, eoi, data_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inta_sequencer dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .interrupt_request_register (irr),
        .interrupt_mask             (mask),
        .highest_level_in_service   (isr),
        .priority_rotate            (rot),
        .special_mask_mode          (smm),
        .inta_n                     (inta_n),
        .vector_base                (vb),
        .auto_eoi_config            (auto_eoi),
        .eoi_command                (eoi_command),
        .eoi_specific               (eoi_specific),
        .eoi_level                  (eoi_level),
        .int_out                    (int_out),
        .latch_in_service           (latch),
        .interrupt                  (interrupt),
        .clear_interrupt_request    (clear),
        .end_of_interrupt           (eoi),
        .data_out                   (data_out),
        .data_out_enable            (den)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase counts INTA falling edges taken in the current acknowledge.
    int         m_phase;
    logic       m_prev, m_spur, m_int_out, m_latch;
    logic [7:0] m_int, m_clr, m_eoi, m_dout, pend, eoi_val;
    int         best, best_rank, isr_rank, r;
    logic       elig, fall;
    logic [2:0] idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_prev = 1'b0; m_spur = 1'b0; m_int_out = 1'b0; m_latch = 1'b0;
            m_int = 8'h00; m_clr = 8'h00; m_eoi = 8'h00; m_dout = 8'h00;
        end else begin
            pend = irr & ~mask;
            best = 0; best_rank = 8; isr_rank = 8;
            for (int l = 0; l < 8; l++) begin
                r = (l - int'(rot) - 1 + 16) % 8;
                if (pend[l] && r < best_rank) begin best_rank = r; best = l; end
                if (isr[l] && r < isr_rank) isr_rank = r;
            end
            elig = (best_rank < 8) && (smm || best_rank < isr_rank);
            fall = m_prev && !inta_n;
            eoi_val = 8'h00;
            if (eoi_command) eoi_val = eoi_specific ? (8'h01 << eoi_level) : isr;
            m_latch = 1'b0; m_clr = 8'h00; m_int_out = 1'b0;
            if (m_phase == 0) begin
                if (fall) begin
                    m_phase = 1;
                    m_int   = elig ? (8'h01 << best) : 8'h80;
                    m_latch = elig;
                    m_clr   = elig ? m_int : 8'h00;
                    m_spur  = !elig;
                end else begin
                    m_int_out = elig;
                end
            end else if (m_phase == 1) begin
                if (fall) begin
                    m_phase = 2;
                    idx = 3'd0;
                    for (int l = 0; l < 8; l++) if (m_int[l]) idx = 3'(l);
                    m_dout = {vb, idx};
                end
            end else if (inta_n) begin
                m_phase = 0;
                if (auto_eoi && !m_spur) eoi_val = eoi_val | m_int;
            end
            m_eoi  = eoi_val;
            m_prev = inta_n;
        end
    end

    always @(negedge clk) begin
        chk("cyc_int_out", {7'd0, int_out}, {7'd0, m_int_out});
        chk("cyc_latch", {7'd0, latch}, {7'd0, m_latch});
        chk("cyc_interrupt", interrupt, m_int);
        chk("cyc_clear", clear, m_clr);
        chk("cyc_eoi", eoi, m_eoi);
        chk("cyc_data_out", data_out, m_dout);
        chk("cyc_den", {7'd0, den}, {7'd0, (m_phase == 2) && !inta_n});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic full_ack(input bit with_eoi, input logic [7:0] irr_mid);
        inta_n = 1'b0; step(1);
        inta_n = 1'b1; irr = irr_mid; step(1);
        inta_n = 1'b0; step(1);
        inta_n = 1'b1;
        if (with_eoi) eoi_command = 1'b1;
        step(1);
        eoi_command = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irr = 8'h00; mask = 8'h00; isr = 8'h00; rot = 3'd7; smm = 1'b0;
        inta_n = 1'b1; vb = 5'h10; auto_eoi = 1'b0; eoi_command = 1'b0; eoi_specific = 1'b0;
        eoi_level = 3'd0;
        @(negedge clk);
        chk("rst_int_out", {7'd0, int_out}, 8'h00);
        chk("rst_interrupt", interrupt, 8'h00);
        chk("rst_data_out", data_out, 8'h00);
        @(posedge clk); #2; rst_n = 1'b1;
        step(2);

        // Basic acknowledge of level 2
        irr = 8'h04; #1;
        chk("int_out_before", {7'd0, int_out}, 8'h00);
        step(1);
        chk("int_out_rise", {7'd0, int_out}, 8'h01);
        inta_n = 1'b0; step(1);
        chk("ack1_interrupt", interrupt, 8'h04);
        chk("ack1_latch", {7'd0, latch}, 8'h01);
        chk("ack1_clear", clear, 8'h04);
        chk("ack1_int_out", {7'd0, int_out}, 8'h00);
        inta_n = 1'b1; step(1);
        chk("latch_one_cycle", {7'd0, latch}, 8'h00);
        chk("clear_one_cycle", clear, 8'h00);
        inta_n = 1'b0; step(1);
        chk("ack2_vector", data_out, 8'h82);
        chk("ack2_den", {7'd0, den}, 8'h01);
        chk("model_vector", m_dout, 8'h82);
        inta_n = 1'b1; #1;
        chk("den_drop", {7'd0, den}, 8'h00);
        step(1);
        chk("no_auto_eoi", eoi, 8'h00);
        irr = 8'h00; step(2);

        // Rotation: level 4 highest, level 7 before wrap
        rot = 3'd3; irr = 8'h81; step(1);
        chk("rot_int_out", {7'd0, int_out}, 8'h01);
        full_ack(1'b0, 8'h81);
        chk("rot_interrupt", interrupt, 8'h80);
        chk("rot_vector", data_out, 8'h87);
        chk("model_rot", m_int, 8'h80);
        irr = 8'h00; rot = 3'd7; step(2);

        // Blocking by in-service level, special mask override, and masking
        irr = 8'h08; isr = 8'h02; step(3);
        chk("blocked", {7'd0, int_out}, 8'h00);
        smm = 1'b1; step(1);
        chk("smm_unblocks", {7'd0, int_out}, 8'h01);
        smm = 1'b0; isr = 8'h00; irr = 8'h04; mask = 8'h04; step(2);
        chk("masked", {7'd0, int_out}, 8'h00);
        mask = 8'h00; irr = 8'h00; step(1);

        // Spurious: request withdrawn before the first INTA, auto-EOI must stay quiet
        auto_eoi = 1'b1; irr = 8'h04; step(1);
        chk("spur_int_out", {7'd0, int_out}, 8'h01);
        irr = 8'h00;
        full_ack(1'b0, 8'h00);
        chk("spur_interrupt", interrupt, 8'h80);
        chk("spur_lsbs", {5'd0, data_out[2:0]}, 8'h07);
        chk("spur_no_eoi", eoi, 8'h00);

        // Auto-EOI on a valid level-2 acknowledge
        irr = 8'h04; step(1);
        full_ack(1'b0, 8'h04);
        chk("auto_eoi", eoi, 8'h04);
        step(1);
        chk("auto_eoi_one_cycle", eoi, 8'h00);

        // Specific EOI level 5 merged with auto-EOI level 2; level 0 arrives mid-acknowledge
        eoi_specific = 1'b1; eoi_level = 3'd5;
        full_ack(1'b1, 8'h01);
        chk("eoi_or", eoi, 8'h24);
        chk("hold_interrupt", interrupt, 8'h04);
        chk("hold_vector", data_out, 8'h82);
        eoi_specific = 1'b0; irr = 8'h00; auto_eoi = 1'b0; step(2);

        // Stand-alone EOI commands
        isr = 8'h10; eoi_command = 1'b1; step(1);
        eoi_command = 1'b0;
        chk("nonspec_eoi", eoi, 8'h10);
        eoi_command = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3; step(1);
        eoi_command = 1'b0;
        chk("spec_eoi", eoi, 8'h08);
        step(1);
        chk("eoi_one_cycle", eoi, 8'h00);
        isr = 8'h00; eoi_specific = 1'b0;

        // Reset in ACK2 aborts with no EOI; a fresh INTA edge is needed afterwards
        irr = 8'h04; auto_eoi = 1'b1; step(1);
        inta_n = 1'b0; step(1);
        inta_n = 1'b1; step(1);
        inta_n = 1'b0; step(1);
        chk("pre_reset_den", {7'd0, den}, 8'h01);
        #1 rst_n = 1'b0; #1;
        chk("arst_int_out", {7'd0, int_out}, 8'h00);
        chk("arst_latch", {7'd0, latch}, 8'h00);
        chk("arst_interrupt", interrupt, 8'h00);
        chk("arst_clear", clear, 8'h00);
        chk("arst_eoi", eoi, 8'h00);
        chk("arst_data_out", data_out, 8'h00);
        chk("arst_den", {7'd0, den}, 8'h00);
        @(posedge clk); #2; rst_n = 1'b1;
        step(2);
        chk("post_reset_eoi", eoi, 8'h00);
        chk("post_reset_interrupt", interrupt, 8'h00);
        chk("post_reset_int_out", {7'd0, int_out}, 8'h01);
        inta_n = 1'b1; step(1);
        full_ack(1'b0, 8'h04);
        chk("post_reset_ack", interrupt, 8'h04);
        chk("post_reset_auto_eoi", eoi, 8'h04);
        irr = 8'h00; auto_eoi = 1'b0; step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
